alu_design: RTL and testbench
=============================

Name: alu_design

Overview:
- Registered 16-bit, 8-operation arithmetic/logic unit with status flags.
- Sits in the datapath as a single-cycle-latency compute stage.
- Its output is checked against expected values by the verification scoreboard.
- One clock domain; asynchronous active-low reset.

Parameters:
- DATA_WIDTH, 16, operand and result width in bits (legal values >= 4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B.
- sel  input  3  operation select.
- in_valid  input  1  operands and sel are valid this cycle.
- out  output  DATA_WIDTH  registered result.
- out_valid  output  1  out holds a result captured on the previous edge.
- carry  output  1  registered carry/borrow flag.
- zero  output  1  registered flag, 1 when the result is all zeros.
- ovf  output  1  registered signed-overflow flag.

Behaviour:
- Reset value (reset=0, asynchronous, applied immediately): out, out_valid, carry, zero and ovf are all 0. Reset dominates clk and in_valid.
- Latency: one cycle. Operands sampled on rising edge N with in_valid=1 appear on out at edge N (visible before edge N+1).
- out_valid equals in_valid registered.
- When in_valid=0: out, carry, zero and ovf hold their previous values; out_valid goes to 0.
- Operations (W = DATA_WIDTH, arithmetic is modulo 2^W):
  - 000 ADD: out = a + b; carry = bit W of the full sum; ovf = signed overflow.
  - 001 SUB: out = a - b; carry = borrow (1 when a < b unsigned); ovf = signed overflow.
  - 010 AND: a & b.
  - 011 OR: a | b.
  - 100 XOR: a ^ b.
  - 101 NOT: ~a; b is ignored.
  - 110 SHL: a << b[3:0]; carry = last bit shifted out, 0 when the shift amount is 0.
  - 111 SHR: logical a >> b[3:0]; carry = last bit shifted out, 0 when the shift amount is 0.
- For logic ops (010-101), carry = 0 and ovf = 0.
- zero is computed from the final registered out value in every operation.
- Shift amount uses only b[3:0]; the upper bits of b are ignored. A shift of 15 is legal.
- No X propagation: unknown sel cannot occur because all 8 codes are defined.
- A reset asserted mid-operation discards the in-flight result. The first valid result after release appears one edge after the first in_valid=1 sample.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: ADD and SUB saturate on signed overflow.
  - Positive overflow gives 0x7FFF (for W=16); negative overflow gives 0x8000.
  - ovf still reports the overflow.
  - carry is unchanged from the wrapping definition.
- Not defined: ADD and SUB wrap modulo 2^W.
- Logic and shift operations are identical in both builds.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 and random a/b. Required: out=0, out_valid=0, carry=0, zero=0, ovf=0. Release reset, apply a=0x0123, b=0x0456, sel=000. Required one edge later: out=0x0579, out_valid=1, carry=0, zero=0, ovf=0. The scoreboard must flag a mismatch when 0x0578 is expected.
- Arithmetic edge cases:
  - ADD 0xFFFF+0x0001 gives out=0x0000, carry=1, zero=1, ovf=0.
  - ADD 0x7FFF+0x0001 gives out=0x8000 and ovf=1. With ALU_SAT_EN the result is 0x7FFF, ovf=1.
  - SUB 0x0003-0x0005 gives out=0xFFFE, carry=1, ovf=0.
- Logic ops with a=0xF0F0, b=0xFF00:
  - AND gives 0xF000.
  - OR gives 0xFFF0.
  - XOR gives 0x0FF0.
  - NOT gives 0x0F0F.
  - carry=0 and ovf=0 for all four.
- Shifts:
  - SHL a=0x8001, b=0x0001 gives out=0x0002, carry=1.
  - SHR a=0x8001, b=0x0010 (shift 0) gives out=0x8001, carry=0.
  - SHR a=0x8000, b=0x000F gives out=0x0001, carry=0.
- Hold and valid: compute ADD 1+1 (out=0x0002), then drop in_valid for 3 cycles while changing a/b/sel. Required: out stays 0x0002, out_valid=0. Re-raise in_valid and the new result appears after one edge.
- Asynchronous reset mid-stream: assert reset between clock edges during back-to-back valid ops. Required: outputs clear immediately without waiting for a clock edge, and the pending result never appears.

Source files
------------

// File: rtl/alu_design.sv
// Registered DATA_WIDTH-bit, 8-operation ALU with carry/zero/overflow flags and one cycle of latency.
// Optional build macro ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
module alu_design #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            sel,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic                  carry,
  output logic                  zero,
  output logic                  ovf
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  op_e          w_op;
  logic [3:0]   w_shamt;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W:0]   w_shl;
  logic [W:0]   w_shr;
  logic         w_add_ovf;
  logic         w_sub_ovf;
  logic [W-1:0] w_res;
  logic         w_carry;
  logic         w_ovf;

  logic [W-1:0] r_out;
  logic         r_valid;
  logic         r_carry;
  logic         r_zero;
  logic         r_ovf;

  assign w_op    = op_e'(sel);
  assign w_shamt = b[3:0];

  // Bit W of the widened sum is the carry; bit W of the widened difference is the borrow.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  // The extra guard bit catches the last bit shifted out; it stays 0 for a zero shift.
  assign w_shl = {1'b0, a} << w_shamt;
  assign w_shr = {a, 1'b0} >> w_shamt;

  assign w_add_ovf = (a[W-1] == b[W-1]) && (w_sum[W-1]  != a[W-1]);
  assign w_sub_ovf = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);

`ifdef ALU_SAT_EN
  // A wrapped result with its sign bit set means the true result was positive, and vice versa.
  function automatic logic [W-1:0] saturate(input logic [W-1:0] res, input logic overflow);
    if (!overflow)
      saturate = res;
    else if (res[W-1])
      saturate = {1'b0, {(W-1){1'b1}}};
    else
      saturate = {1'b1, {(W-1){1'b0}}};
  endfunction
`else
  function automatic logic [W-1:0] saturate(input logic [W-1:0] res, input logic overflow);
    saturate = overflow ? res : res;
  endfunction
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res   = saturate(w_sum[W-1:0], w_add_ovf);
        w_carry = w_sum[W];
        w_ovf   = w_add_ovf;
      end
      OP_SUB: begin
        w_res   = saturate(w_diff[W-1:0], w_sub_ovf);
        w_carry = w_diff[W];
        w_ovf   = w_sub_ovf;
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      OP_SHL: begin
        w_res   = w_shl[W-1:0];
        w_carry = w_shl[W];
      end
      OP_SHR: begin
        w_res   = w_shr[W:1];
        w_carry = w_shr[0];
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out   <= w_res;
        r_carry <= w_carry;
        r_zero  <= (w_res == '0);
        r_ovf   <= w_ovf;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_alu_design.sv
// Directed self-checking bench for alu_design (DATA_WIDTH=16); expectations track ALU_SAT_EN.
module tb_alu_design;

  logic        clk;
  logic        reset;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  sel;
  logic        in_valid;
  logic [15:0] out;
  logic        out_valid;
  logic        carry;
  logic        zero;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sel;
    logic [15:0] out;
    logic        c;
    logic        z;
    logic        o;
  } vec_t;

  alu_design #(.DATA_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: out, then flags in the order valid, carry, zero, ovf.
  logic [19:0] obs;
  assign obs = {out, out_valid, carry, zero, ovf};

  function automatic vec_t mk(string name, logic [15:0] va, logic [15:0] vb, logic [2:0] vs,
                              logic [15:0] vo, logic vc, logic vz, logic vov);
    vec_t v;
    v.name = name; v.a = va; v.b = vb; v.sel = vs;
    v.out = vo; v.c = vc; v.z = vz; v.o = vov;
    return v;
  endfunction

  task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] vs,
                       input logic vv);
    @(negedge clk);
    a = va; b = vb; sel = vs; in_valid = vv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] exp;
    reset = 1'b0;
    in_valid = 1'b1;
    a = 16'($urandom); b = 16'($urandom); sel = 3'($urandom);
    #1;
    exp = 20'h0;
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_initial: got out=%h vczo=%b expected out=%h vczo=%b", obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); sel = 3'($urandom);
      step();
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL reset_hold_%0d: got out=%h vczo=%b expected out=%h vczo=%b", i, obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    a = 16'h0123; b = 16'h0456; sel = 3'b000; in_valid = 1'b1;
    step();
    exp = {16'h0579, 4'b1000};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_first_add: got out=%h vczo=%b expected out=%h vczo=%b", obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  task automatic test_arith();
    vec_t v[5];
    logic [19:0] exp;
    v[0] = mk("add_wrap_zero", 16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b1, 1'b1, 1'b0);
`ifdef ALU_SAT_EN
    v[1] = mk("add_pos_ovf",   16'h7FFF, 16'h0001, 3'b000, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    v[3] = mk("sub_neg_ovf",   16'h8000, 16'h0001, 3'b001, 16'h8000, 1'b0, 1'b0, 1'b1);
`else
    v[1] = mk("add_pos_ovf",   16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b0, 1'b0, 1'b1);
    v[3] = mk("sub_neg_ovf",   16'h8000, 16'h0001, 3'b001, 16'h7FFF, 1'b0, 1'b0, 1'b1);
`endif
    v[2] = mk("sub_borrow",    16'h0003, 16'h0005, 3'b001, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    v[4] = mk("sub_equal",     16'h1234, 16'h1234, 3'b001, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(v[i].a, v[i].b, v[i].sel, 1'b1);
      step();
      exp = {v[i].out, 1'b1, v[i].c, v[i].z, v[i].o};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s: got out=%h vczo=%b expected out=%h vczo=%b", v[i].name, obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[5];
    logic [19:0] exp;
    v[0] = mk("and",      16'hF0F0, 16'hFF00, 3'b010, 16'hF000, 1'b0, 1'b0, 1'b0);
    v[1] = mk("or",       16'hF0F0, 16'hFF00, 3'b011, 16'hFFF0, 1'b0, 1'b0, 1'b0);
    v[2] = mk("xor",      16'hF0F0, 16'hFF00, 3'b100, 16'h0FF0, 1'b0, 1'b0, 1'b0);
    v[3] = mk("not",      16'hF0F0, 16'hFF00, 3'b101, 16'h0F0F, 1'b0, 1'b0, 1'b0);
    v[4] = mk("and_zero", 16'h00FF, 16'hFF00, 3'b010, 16'h0000, 1'b0, 1'b1, 1'b0);
    // Leave carry/ovf set beforehand so a logic op that fails to clear them is caught.
    drive(16'hFFFF, 16'h0001, 3'b000, 1'b1);
    step();
    drive(16'h7FFF, 16'h0001, 3'b000, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(v[i].a, v[i].b, v[i].sel, 1'b1);
      step();
      exp = {v[i].out, 1'b1, v[i].c, v[i].z, v[i].o};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s: got out=%h vczo=%b expected out=%h vczo=%b", v[i].name, obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[6];
    logic [19:0] exp;
    v[0] = mk("shl_1",        16'h8001, 16'h0001, 3'b110, 16'h0002, 1'b1, 1'b0, 1'b0);
    v[1] = mk("shr_0",        16'h8001, 16'h0010, 3'b111, 16'h8001, 1'b0, 1'b0, 1'b0);
    v[2] = mk("shr_15",       16'h8000, 16'h000F, 3'b111, 16'h0001, 1'b0, 1'b0, 1'b0);
    v[3] = mk("shr_1_carry",  16'h0003, 16'h0001, 3'b111, 16'h0001, 1'b1, 1'b0, 1'b0);
    v[4] = mk("shl_15",       16'h0003, 16'h000F, 3'b110, 16'h8000, 1'b1, 1'b0, 1'b0);
    v[5] = mk("shl_hi_b_ign", 16'h00F0, 16'hFFF4, 3'b110, 16'h0F00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(v[i].a, v[i].b, v[i].sel, 1'b1);
      step();
      exp = {v[i].out, 1'b1, v[i].c, v[i].z, v[i].o};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s: got out=%h vczo=%b expected out=%h vczo=%b", v[i].name, obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_hold();
    logic [19:0] exp;
    drive(16'h0001, 16'h0001, 3'b000, 1'b1);
    step();
    exp = {16'h0002, 4'b1000};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL hold_add: got out=%h vczo=%b expected out=%h vczo=%b", obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
    exp = {16'h0002, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      drive(16'hFFFF - 16'(i), 16'h0001 + 16'(i), 3'(i + 1), 1'b0);
      step();
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL hold_idle_%0d: got out=%h vczo=%b expected out=%h vczo=%b", i, obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
      end
    end
    drive(16'h00FF, 16'h0F0F, 3'b100, 1'b1);
    step();
    exp = {16'h0FF0, 4'b1000};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL hold_resume: got out=%h vczo=%b expected out=%h vczo=%b", obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  task automatic test_async_reset();
    logic [19:0] exp;
    drive(16'h1000, 16'h0234, 3'b000, 1'b1);
    step();
    exp = {16'h1234, 4'b1000};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL async_pre: got out=%h vczo=%b expected out=%h vczo=%b", obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
    // Next op is in flight; reset lands between edges and must clear without a clock.
    drive(16'hFFFF, 16'h0001, 3'b000, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    exp = 20'h0;
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL async_clear: got out=%h vczo=%b expected out=%h vczo=%b", obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
    step();
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL async_held: got out=%h vczo=%b expected out=%h vczo=%b", obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL async_no_pending: got out=%h vczo=%b expected out=%h vczo=%b", obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
    drive(16'h0005, 16'h0003, 3'b001, 1'b1);
    step();
    exp = {16'h0002, 4'b1000};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL async_first_after: got out=%h vczo=%b expected out=%h vczo=%b", obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_hold();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
